// File: rtl/tmr_test_pkg.sv
// Shared helpers for the TMR pass test pipeline.
package tmr_test_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline register stage: data plus valid bit, with stall and flush.
module dff_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // Flush only clears validity; the data registers keep their contents.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = d_data;
            valid_d = d_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_data  = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe_tmr.sv
// DEPTH-stage valid-tracked register pipeline with flush, stall, optional
// output inversion and occupancy count; target design for triplication.
(* tamara_triplicate *)
module dff_pipe_tmr
    import tmr_test_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter bit INVERT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          a,
    input  logic                      in_valid,
    output logic [WIDTH-1:0]          o,
    output logic                      out_valid,
    output logic [cnt_w(DEPTH)-1:0]   count,
    (* tamara_error_sink *)
    output logic                      err
);

    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_t;

    if (WIDTH < 1 || DEPTH < 1) begin : g_param_err
        $error("dff_pipe_tmr: WIDTH and DEPTH must both be >= 1");
    end

    logic [DEPTH:0][WIDTH-1:0] chain_data;
    logic [DEPTH:0]            chain_valid;
    stage_t                    last_stage;

    assign chain_data[0]  = a;
    assign chain_valid[0] = in_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .flush   (flush),
            .d_data  (chain_data[k]),
            .d_valid (chain_valid[k]),
            .q_data  (chain_data[k+1]),
            .q_valid (chain_valid[k+1])
        );
    end

    assign last_stage = '{data: chain_data[DEPTH], valid: chain_valid[DEPTH]};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Modular add/subtract is exact here: the true result always lies in 0..DEPTH.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(in_valid) - CW'(last_stage.valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        o = INVERT ? ~last_stage.data : last_stage.data;
    end

    assign out_valid = last_stage.valid;
    assign count     = count_q;

`ifndef TAMARA
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe_tmr.sv
// Directed vector bench for dff_pipe_tmr (8x3 inverting and 1x1 inverting).
module tb_dff_pipe_tmr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, flush, in_valid;
    logic [7:0] a;
    logic [7:0] o;
    logic       out_valid;
    logic [1:0] count;
    logic       err;

    logic       en1, flush1, iv1;
    logic [0:0] a1;
    logic [0:0] o1;
    logic       ov1;
    logic [0:0] count1;
    logic       err1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dff_pipe_tmr #(.WIDTH(8), .DEPTH(3), .INVERT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .a(a),
        .in_valid(in_valid), .o(o), .out_valid(out_valid), .count(count), .err(err)
    );

    dff_pipe_tmr #(.WIDTH(1), .DEPTH(1), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .flush(flush1), .a(a1),
        .in_valid(iv1), .o(o1), .out_valid(ov1), .count(count1), .err(err1)
    );

    typedef struct {
        logic       en;
        logic       flush;
        logic       iv;
        logic [7:0] a;
        logic [7:0] exp_o;
        logic       exp_ov;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic f, input logic v, input logic [7:0] d,
                       input logic [7:0] eo, input logic eov, input logic [1:0] ec);
        vec_t t;
        t.en = e; t.flush = f; t.iv = v; t.a = d;
        t.exp_o = eo; t.exp_ov = eov; t.exp_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic step1(input logic e, input logic f, input logic v, input logic d);
        @(negedge clk);
        en1 = e; flush1 = f; iv1 = v; a1 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; flush = 1'b0; in_valid = 1'b0; a = 8'h00;
        en1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; a1 = 1'b0;

        // single word
        add(1,0,1,8'h5A, 8'hFF,0,1);
        add(1,0,0,8'h00, 8'hFF,0,1);
        add(1,0,0,8'h00, 8'hA5,1,1);
        add(1,0,0,8'h00, 8'hFF,0,0);
        // back-to-back stream
        add(1,0,1,8'h01, 8'hFF,0,1);
        add(1,0,1,8'h02, 8'hFF,0,2);
        add(1,0,1,8'h03, 8'hFE,1,3);
        add(1,0,1,8'h04, 8'hFD,1,3);
        add(1,0,0,8'h00, 8'hFC,1,2);
        add(1,0,0,8'h00, 8'hFB,1,1);
        add(1,0,0,8'h00, 8'hFF,0,0);
        // stall with a word sitting in the last stage
        add(1,0,1,8'h11, 8'hFF,0,1);
        add(1,0,1,8'h22, 8'hFF,0,2);
        add(1,0,0,8'h00, 8'hEE,1,2);
        for (int i = 0; i < 5; i++) add(0,0,1,8'h77, 8'hEE,1,2);
        add(1,0,0,8'h00, 8'hDD,1,1);
        add(1,0,0,8'h00, 8'hFF,0,0);
        // flush with in_valid; data keeps shifting but stays invalid
        add(1,0,1,8'h33, 8'hFF,0,1);
        add(1,0,1,8'h44, 8'hFF,0,2);
        add(1,1,1,8'h55, 8'hFF,0,0);
        add(1,0,0,8'h00, 8'hCC,0,0);
        add(1,0,0,8'h00, 8'hBB,0,0);
        add(1,0,0,8'h00, 8'hFF,0,0);
        // flush wins over a stall
        add(1,0,1,8'h66, 8'hFF,0,1);
        add(0,1,0,8'h00, 8'hFF,0,0);
        add(1,0,0,8'h00, 8'hFF,0,0);
        add(1,0,0,8'h00, 8'h99,0,0);
        add(1,0,0,8'h00, 8'hFF,0,0);

        #12;
        check("rst_o", 0, o, 8'hFF);
        check("rst_ov", 0, out_valid, 1'b0);
        check("rst_cnt", 0, count, 2'd0);
        check("rst_err", 0, err, 1'b0);
        check("rst_o1", 0, o1, 1'b1);
        check("rst_ov1", 0, ov1, 1'b0);
        check("rst_err1", 0, err1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; flush = vecs[i].flush;
            in_valid = vecs[i].iv; a = vecs[i].a;
            @(posedge clk);
            #1;
            check("vec_o", i, o, vecs[i].exp_o);
            check("vec_ov", i, out_valid, vecs[i].exp_ov);
            check("vec_cnt", i, count, vecs[i].exp_cnt);
        end

        // asynchronous reset mid-stream
        @(negedge clk); en = 1'b1; flush = 1'b0; in_valid = 1'b1; a = 8'hC3;
        @(negedge clk); a = 8'h3C;
        @(negedge clk); a = 8'h0F;
        @(posedge clk); #1;
        check("pre_rst_o", 0, o, 8'h3C);
        check("pre_rst_cnt", 0, count, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_o", 0, o, 8'hFF);
        check("async_ov", 0, out_valid, 1'b0);
        check("async_cnt", 0, count, 2'd0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0; a = 8'h00;
        @(posedge clk); #1;
        check("post_rst_o", 0, o, 8'hFF);
        check("post_rst_cnt", 0, count, 2'd0);

        // WIDTH=1, DEPTH=1 instance: flop into an inverter
        step1(1,0,1,1'b1);
        check("w1_o", 0, o1, 1'b0);
        check("w1_ov", 0, ov1, 1'b1);
        check("w1_cnt", 0, count1, 1'b1);
        step1(1,0,1,1'b0);
        check("w1_o", 1, o1, 1'b1);
        check("w1_ov", 1, ov1, 1'b1);
        check("w1_cnt", 1, count1, 1'b1);
        step1(1,0,0,1'b1);
        check("w1_o", 2, o1, 1'b0);
        check("w1_ov", 2, ov1, 1'b0);
        check("w1_cnt", 2, count1, 1'b0);
        step1(1,0,1,1'b1);
        step1(1,1,1,1'b0);
        check("w1_flush_o", 0, o1, 1'b0);
        check("w1_flush_ov", 0, ov1, 1'b0);
        check("w1_flush_cnt", 0, count1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
